// File: rtl/problem_stream_packer.sv
// Serialises a problem (config, shapes with cells, regions) into the accelerator's 32-bit word stream.
// Optional checksum trailer word: define STREAM_PACKER_TRAILER_EN.
module problem_stream_packer #(
  parameter int MAX_SHAPES = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        cfg_num_shapes,
  input  logic [CNT_W-1:0]        cfg_num_regions,
  input  logic                    shp_valid,
  output logic                    shp_ready,
  input  logic [7:0]              shp_w,
  input  logic [7:0]              shp_h,
  input  logic [7:0]              shp_num_cells,
  input  logic                    cell_valid,
  output logic                    cell_ready,
  input  logic [3:0]              cell_x,
  input  logic [3:0]              cell_y,
  input  logic                    rgn_valid,
  output logic                    rgn_ready,
  input  logic [15:0]             rgn_w,
  input  logic [15:0]             rgn_h,
  input  logic [8*MAX_SHAPES-1:0] rgn_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int QW = 8 * MAX_SHAPES;

  typedef enum logic [2:0] {
    IDLE, HDR, SHP_HDR, SHP_CELLS, RGN_HDR, RGN_Q0, RGN_Q1, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  nshp_q, nshp_d, nrgn_q, nrgn_d;
  logic [CNT_W-1:0]  shp_idx_q, shp_idx_d, rgn_idx_q, rgn_idx_d;
  logic [7:0]        cells_left_q, cells_left_d;
  logic [1:0]        lane_idx_q, lane_idx_d;
  logic [31:0]       pack_q, pack_d;
  logic [QW-1:0]     qty_q, qty_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              busy_q, busy_d;
`ifdef STREAM_PACKER_TRAILER_EN
  logic [31:0]       acc_q, acc_d;
  logic              trl_sent_q, trl_sent_d;
`endif

  logic              load_ok, emit, shape_done, done_c;
  logic [31:0]       word, cell_word;
  logic [63:0]       qty_ext;

  assign load_ok    = !out_valid_q || out_ready;
  assign shp_ready  = !rst && (state_q == SHP_HDR)   && load_ok;
  assign cell_ready = !rst && (state_q == SHP_CELLS) && load_ok;
  assign rgn_ready  = !rst && (state_q == RGN_HDR)   && load_ok;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign done       = !rst && done_c;

  // Quantity lanes beyond MAX_SHAPES read as zero.
  always_comb begin
    qty_ext         = '0;
    qty_ext[QW-1:0] = qty_q;
  end

  always_comb begin
    state_d      = state_q;
    nshp_d       = nshp_q;
    nrgn_d       = nrgn_q;
    shp_idx_d    = shp_idx_q;
    rgn_idx_d    = rgn_idx_q;
    cells_left_d = cells_left_q;
    lane_idx_d   = lane_idx_q;
    pack_d       = pack_q;
    qty_d        = qty_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    busy_d       = busy_q;
`ifdef STREAM_PACKER_TRAILER_EN
    acc_d        = acc_q;
    trl_sent_d   = trl_sent_q;
`endif
    emit         = 1'b0;
    shape_done   = 1'b0;
    done_c       = 1'b0;
    word         = '0;
    cell_word    = pack_q | ({24'h0, cell_y, cell_x} << {lane_idx_q, 3'b000});

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          nshp_d    = cfg_num_shapes;
          nrgn_d    = cfg_num_regions;
          shp_idx_d = '0;
          rgn_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (load_ok) begin
          emit = 1'b1;
          word = {16'(nrgn_q), 16'(nshp_q)};
          if (nshp_q != '0)      state_d = SHP_HDR;
          else if (nrgn_q != '0) state_d = RGN_HDR;
          else                   state_d = FIN;
        end
      end
      SHP_HDR: begin
        if (shp_valid && load_ok) begin
          emit = 1'b1;
          word = {8'h00, shp_num_cells, shp_h, shp_w};
          if (shp_num_cells == 8'd0) begin
            shape_done = 1'b1;
          end else begin
            cells_left_d = shp_num_cells;
            lane_idx_d   = 2'd0;
            pack_d       = '0;
            state_d      = SHP_CELLS;
          end
        end
      end
      SHP_CELLS: begin
        if (cell_valid && load_ok) begin
          cells_left_d = cells_left_q - 8'd1;
          // Flush on a full word or on the shape's last cell.
          if (lane_idx_q == 2'd3 || cells_left_q == 8'd1) begin
            emit       = 1'b1;
            word       = cell_word;
            pack_d     = '0;
            lane_idx_d = 2'd0;
          end else begin
            pack_d     = cell_word;
            lane_idx_d = lane_idx_q + 2'd1;
          end
          if (cells_left_q == 8'd1) shape_done = 1'b1;
        end
      end
      RGN_HDR: begin
        if (rgn_valid && load_ok) begin
          emit    = 1'b1;
          word    = {rgn_h, rgn_w};
          qty_d   = rgn_q;
          state_d = RGN_Q0;
        end
      end
      RGN_Q0: begin
        if (load_ok) begin
          emit    = 1'b1;
          word    = qty_ext[31:0];
          state_d = RGN_Q1;
        end
      end
      RGN_Q1: begin
        if (load_ok) begin
          emit      = 1'b1;
          word      = qty_ext[63:32];
          rgn_idx_d = rgn_idx_q + CNT_W'(1);
          state_d   = (rgn_idx_q + CNT_W'(1) == nrgn_q) ? FIN : RGN_HDR;
        end
      end
      FIN: begin
`ifdef STREAM_PACKER_TRAILER_EN
        if (!trl_sent_q) begin
          if (load_ok) begin
            emit       = 1'b1;
            word       = acc_q;
            trl_sent_d = 1'b1;
          end
        end else if (out_valid_q && out_ready) begin
          done_c     = 1'b1;
          busy_d     = 1'b0;
          trl_sent_d = 1'b0;
          state_d    = IDLE;
        end
`else
        if (out_valid_q && out_ready) begin
          done_c  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (shape_done) begin
      shp_idx_d = shp_idx_q + CNT_W'(1);
      if (shp_idx_q + CNT_W'(1) == nshp_q) state_d = (nrgn_q != '0) ? RGN_HDR : FIN;
      else                                 state_d = SHP_HDR;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
`ifdef STREAM_PACKER_TRAILER_EN
      acc_d       = (state_q == HDR) ? word : (acc_q ^ word);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      nshp_q       <= '0;
      nrgn_q       <= '0;
      shp_idx_q    <= '0;
      rgn_idx_q    <= '0;
      cells_left_q <= '0;
      lane_idx_q   <= '0;
      pack_q       <= '0;
      qty_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
`ifdef STREAM_PACKER_TRAILER_EN
      acc_q        <= '0;
      trl_sent_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      nshp_q       <= nshp_d;
      nrgn_q       <= nrgn_d;
      shp_idx_q    <= shp_idx_d;
      rgn_idx_q    <= rgn_idx_d;
      cells_left_q <= cells_left_d;
      lane_idx_q   <= lane_idx_d;
      pack_q       <= pack_d;
      qty_q        <= qty_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
`ifdef STREAM_PACKER_TRAILER_EN
      acc_q        <= acc_d;
      trl_sent_q   <= trl_sent_d;
`endif
    end
  end

endmodule

// File: tb/tb_problem_stream_packer.sv
// Directed bench for problem_stream_packer (default build, no trailer word).
module tb_problem_stream_packer;

  logic        clk, rst, start;
  logic [15:0] cfg_num_shapes, cfg_num_regions;
  logic        shp_valid, shp_ready, shp_ready3;
  logic [7:0]  shp_w, shp_h, shp_num_cells;
  logic        cell_valid, cell_ready, cell_ready3;
  logic [3:0]  cell_x, cell_y;
  logic        rgn_valid, rgn_ready, rgn_ready3;
  logic [15:0] rgn_w, rgn_h;
  logic [63:0] rgn_q;
  logic        out_valid, out_valid3, out_ready;
  logic [31:0] out_data, out_data3;
  logic        busy, busy3, done, done3;

  int chk = 0, pass = 0, timeouts = 0, stall_err = 0, done_cnt = 0;
  logic [31:0] wq[$], wq3[$];
  logic        rdy_pat = 1'b0;
  int          rdy_ph = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  logic [31:0] exp_basic [7] = '{32'h00010001, 32'h00050303, 32'h10020100, 32'h00000011,
                                 32'h00040004, 32'h00000002, 32'h00000000};
  logic [31:0] exp_zc    [4] = '{32'h00000002, 32'h00000101, 32'h00040202, 32'h11100100};
  logic [31:0] exp_m3    [4] = '{32'h00010000, 32'h00060005, 32'h00090807, 32'h00000000};
  logic [31:0] exp_m8    [4] = '{32'h00010000, 32'h00060005, 32'hAA090807, 32'hAAAAAAAA};

  problem_stream_packer #(.MAX_SHAPES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_shapes(cfg_num_shapes), .cfg_num_regions(cfg_num_regions),
    .shp_valid(shp_valid), .shp_ready(shp_ready), .shp_w(shp_w), .shp_h(shp_h),
    .shp_num_cells(shp_num_cells),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_x(cell_x), .cell_y(cell_y),
    .rgn_valid(rgn_valid), .rgn_ready(rgn_ready), .rgn_w(rgn_w), .rgn_h(rgn_h), .rgn_q(rgn_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  problem_stream_packer #(.MAX_SHAPES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_shapes(cfg_num_shapes), .cfg_num_regions(cfg_num_regions),
    .shp_valid(shp_valid), .shp_ready(shp_ready3), .shp_w(shp_w), .shp_h(shp_h),
    .shp_num_cells(shp_num_cells),
    .cell_valid(cell_valid), .cell_ready(cell_ready3), .cell_x(cell_x), .cell_y(cell_y),
    .rgn_valid(rgn_valid), .rgn_ready(rgn_ready3), .rgn_w(rgn_w), .rgn_h(rgn_h),
    .rgn_q(rgn_q[23:0]),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .busy(busy3), .done(done3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_pat) begin
        out_ready = (rdy_ph == 0) || (rdy_ph == 3);
        rdy_ph = (rdy_ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Word capture and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        wq.push_back(out_data);
        wq3.push_back(out_data3);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_stream(input logic [15:0] ns, input logic [15:0] nr);
    @(posedge clk); #1;
    cfg_num_shapes = ns; cfg_num_regions = nr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_shape(input logic [7:0] w, input logic [7:0] h, input logic [7:0] n);
    int k;
    k = 0;
    shp_w = w; shp_h = h; shp_num_cells = n; shp_valid = 1'b1;
    @(negedge clk);
    while (!shp_ready && k < 100) begin @(negedge clk); k++; end
    if (!shp_ready) timeouts++;
    @(posedge clk); #1;
    shp_valid = 1'b0;
  endtask

  task automatic send_cell(input logic [3:0] x, input logic [3:0] y);
    int k;
    k = 0;
    cell_x = x; cell_y = y; cell_valid = 1'b1;
    @(negedge clk);
    while (!cell_ready && k < 100) begin @(negedge clk); k++; end
    if (!cell_ready) timeouts++;
    @(posedge clk); #1;
    cell_valid = 1'b0;
  endtask

  task automatic send_rgn(input logic [15:0] w, input logic [15:0] h, input logic [63:0] q);
    int k;
    k = 0;
    rgn_w = w; rgn_h = h; rgn_q = q; rgn_valid = 1'b1;
    @(negedge clk);
    while (!rgn_ready && k < 100) begin @(negedge clk); k++; end
    if (!rgn_ready) timeouts++;
    @(posedge clk); #1;
    rgn_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 300) begin @(negedge clk); k++; end
    if (busy) timeouts++;
  endtask

  task automatic send_basic(input bit poke_start);
    start_stream(16'd1, 16'd1);
    send_shape(8'd3, 8'd3, 8'd5);
    if (poke_start) begin
      cfg_num_shapes = 16'd5; cfg_num_regions = 16'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    send_cell(4'd0, 4'd0);
    send_cell(4'd1, 4'd0);
    send_cell(4'd2, 4'd0);
    send_cell(4'd0, 4'd1);
    send_cell(4'd1, 4'd1);
    send_rgn(16'd4, 16'd4, 64'h2);
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    shp_valid = 1'b1; cell_valid = 1'b1; rgn_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass++;
    chk++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 00000000", out_data); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
    chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass++;
    chk++; if ({shp_ready, cell_ready, rgn_ready} !== 3'b000)
      $display("FAIL idle_readies: got %b want 000", {shp_ready, cell_ready, rgn_ready}); else pass++;
    @(posedge clk); #1;
    shp_valid = 1'b0; cell_valid = 1'b0; rgn_valid = 1'b0;
  endtask

  task automatic test_empty();
    int bcnt, d0, k;
    wq.delete(); d0 = done_cnt; bcnt = 0; k = 0;
    start_stream(16'd0, 16'd0);
    @(negedge clk);
    while (busy && k < 50) begin bcnt++; @(negedge clk); k++; end
    if (busy) timeouts++;
    chk++; if (wq.size() !== 1) $display("FAIL empty_count: got %0d want 1", wq.size()); else pass++;
    chk++; if (wq.size() > 0 && wq[0] !== 32'h0) $display("FAIL empty_word: got %h want 00000000", wq[0]); else pass++;
    chk++; if (bcnt !== 2) $display("FAIL empty_busy_cycles: got %0d want 2", bcnt); else pass++;
    chk++; if (done_cnt - d0 !== 1) $display("FAIL empty_done: got %0d want 1", done_cnt - d0); else pass++;
  endtask

  task automatic test_basic();
    int d0;
    logic [31:0] got;
    wq.delete(); d0 = done_cnt;
    send_basic(1'b0);
    chk++; if (wq.size() !== 7) $display("FAIL basic_count: got %0d want 7", wq.size()); else pass++;
    for (int i = 0; i < 7; i++) begin
      got = (i < wq.size()) ? wq[i] : 32'hDEADBEEF;
      chk++; if (got !== exp_basic[i]) $display("FAIL basic_word%0d: got %h want %h", i, got, exp_basic[i]); else pass++;
    end
    chk++; if (done_cnt - d0 !== 1) $display("FAIL basic_done: got %0d want 1", done_cnt - d0); else pass++;
  endtask

  task automatic test_back_to_back_stall();
    int d0;
    logic [31:0] got;
    wq.delete(); d0 = done_cnt; stall_err = 0;
    rdy_ph = 0; rdy_pat = 1'b1;
    send_basic(1'b1);
    rdy_pat = 1'b0;
    @(posedge clk); #1;
    chk++; if (wq.size() !== 7) $display("FAIL stall_count: got %0d want 7", wq.size()); else pass++;
    for (int i = 0; i < 7; i++) begin
      got = (i < wq.size()) ? wq[i] : 32'hDEADBEEF;
      chk++; if (got !== exp_basic[i]) $display("FAIL stall_word%0d: got %h want %h", i, got, exp_basic[i]); else pass++;
    end
    chk++; if (stall_err !== 0) $display("FAIL stall_stable: got %0d violations want 0", stall_err); else pass++;
    chk++; if (done_cnt - d0 !== 1) $display("FAIL stall_done: got %0d want 1", done_cnt - d0); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL stall_busy_after: got %b want 0", busy); else pass++;
  endtask

  task automatic test_zero_cells();
    logic [31:0] got;
    wq.delete();
    start_stream(16'd2, 16'd0);
    send_shape(8'd1, 8'd1, 8'd0);
    send_shape(8'd2, 8'd2, 8'd4);
    send_cell(4'd0, 4'd0);
    send_cell(4'd1, 4'd0);
    send_cell(4'd0, 4'd1);
    send_cell(4'd1, 4'd1);
    wait_idle();
    chk++; if (wq.size() !== 4) $display("FAIL zc_count: got %0d want 4", wq.size()); else pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < wq.size()) ? wq[i] : 32'hDEADBEEF;
      chk++; if (got !== exp_zc[i]) $display("FAIL zc_word%0d: got %h want %h", i, got, exp_zc[i]); else pass++;
    end
  endtask

  task automatic test_max_shapes();
    logic [31:0] got;
    wq.delete(); wq3.delete();
    start_stream(16'd0, 16'd1);
    send_rgn(16'd5, 16'd6, 64'hAAAA_AAAA_AA09_0807);
    wait_idle();
    chk++; if (wq3.size() !== 4) $display("FAIL m3_count: got %0d want 4", wq3.size()); else pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < wq3.size()) ? wq3[i] : 32'hDEADBEEF;
      chk++; if (got !== exp_m3[i]) $display("FAIL m3_word%0d: got %h want %h", i, got, exp_m3[i]); else pass++;
      got = (i < wq.size()) ? wq[i] : 32'hDEADBEEF;
      chk++; if (got !== exp_m8[i]) $display("FAIL m8_word%0d: got %h want %h", i, got, exp_m8[i]); else pass++;
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_stream(16'd1, 16'd0);
    send_shape(8'd2, 8'd2, 8'd8);
    send_cell(4'd3, 4'd2);
    send_cell(4'd1, 4'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass++;
    chk++; if (cell_ready !== 1'b0) $display("FAIL midrst_cell_ready: got %b want 0", cell_ready); else pass++;
    wq.delete(); d0 = done_cnt;
    start_stream(16'd0, 16'd0);
    wait_idle();
    chk++; if (wq.size() !== 1) $display("FAIL midrst_count: got %0d want 1", wq.size()); else pass++;
    chk++; if (wq.size() > 0 && wq[0] !== 32'h0) $display("FAIL midrst_word: got %h want 00000000", wq[0]); else pass++;
    chk++; if (done_cnt - d0 !== 1) $display("FAIL midrst_done: got %0d want 1", done_cnt - d0); else pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_num_shapes = '0; cfg_num_regions = '0;
    shp_valid = 1'b0; shp_w = '0; shp_h = '0; shp_num_cells = '0;
    cell_valid = 1'b0; cell_x = '0; cell_y = '0;
    rgn_valid = 1'b0; rgn_w = '0; rgn_h = '0; rgn_q = '0;
    test_reset();
    test_empty();
    test_basic();
    test_back_to_back_stall();
    test_zero_cells();
    test_max_shapes();
    test_reset_mid();
    chk++; if (timeouts !== 0) $display("FAIL handshake_timeouts: got %0d want 0", timeouts); else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
